lfsr_pattern_checker: RTL and testbench



---
 rtl/lfsr_pattern_checker.sv | 181 ++++++++++++++++++
 tb/tb_lfsr_pattern_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_pattern_checker.sv
// Receive-side checker for the 9-bit x^9+x^5+1 LFSR pattern stream: self-syncs, then counts errors.
// Define ERR_CAPTURE_EN to add first-mismatch capture outputs (first_err_exp/rcv/idx).
module lfsr_pattern_checker #(
   parameter int unsigned SYNC_COUNT  = 3,
   parameter int unsigned LOSS_COUNT  = 4,
   parameter int unsigned ERR_LIMIT   = 1,
   parameter int unsigned PATTERN_LEN = 511
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        data_valid,
   input  logic [8:0]  data_in,
   output logic        locked,
   output logic        done,
   output logic        fault_detected,
   output logic [15:0] err_count,
`ifdef ERR_CAPTURE_EN
   output logic [8:0]  first_err_exp,
   output logic [8:0]  first_err_rcv,
   output logic [15:0] first_err_idx,
`endif
   output logic [15:0] word_count
);

   localparam logic [3:0]  SyncCnt = 4'(SYNC_COUNT);
   localparam logic [3:0]  LossCnt = 4'(LOSS_COUNT);
   localparam logic [15:0] ErrLim  = 16'(ERR_LIMIT);
   localparam logic [15:0] PatLen  = 16'(PATTERN_LEN);

   typedef enum logic [1:0] {StIdle, StHunt, StLocked, StDone} state_e;

   state_e      state_q, state_d;
   logic [8:0]  exp_q, exp_d;
   logic [3:0]  match_q, match_d;
   logic [3:0]  miss_q, miss_d;
   logic [15:0] err_q, err_d;
   logic [15:0] word_q, word_d;
   logic        locked_q, locked_d;
   logic        done_q, done_d;
   logic        fault_q, fault_d;
`ifdef ERR_CAPTURE_EN
   logic        cap_q, cap_d;
   logic [8:0]  cap_exp_q, cap_exp_d;
   logic [8:0]  cap_rcv_q, cap_rcv_d;
   logic [15:0] cap_idx_q, cap_idx_d;
`endif

   function automatic logic [8:0] lfsr_next(input logic [8:0] s);
      return {s[7:0], s[8] ^ s[4]};
   endfunction

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      match_d  = match_q;
      miss_d   = miss_q;
      err_d    = err_q;
      word_d   = word_q;
      locked_d = locked_q;
      done_d   = done_q;
      // Fault follows err_count by one cycle since it looks at the registered count.
      fault_d  = fault_q | (err_q >= ErrLim);
`ifdef ERR_CAPTURE_EN
      cap_d     = cap_q;
      cap_exp_d = cap_exp_q;
      cap_rcv_d = cap_rcv_q;
      cap_idx_d = cap_idx_q;
`endif
      if (start) begin
         state_d  = StHunt;
         match_d  = '0;
         miss_d   = '0;
         err_d    = '0;
         word_d   = '0;
         locked_d = 1'b0;
         done_d   = 1'b0;
         fault_d  = 1'b0;
`ifdef ERR_CAPTURE_EN
         cap_d     = 1'b0;
         cap_exp_d = '0;
         cap_rcv_d = '0;
         cap_idx_d = '0;
`endif
      end else if (data_valid) begin
         case (state_q)
            StHunt: begin
               if (data_in == 9'h000) begin
                  match_d = '0;
               end else begin
                  exp_d = lfsr_next(data_in);
                  if (match_q == 4'd0 || data_in != exp_q) match_d = 4'd1;
                  else                                    match_d = match_q + 4'd1;
                  if (match_d == SyncCnt) begin
                     state_d  = StLocked;
                     locked_d = 1'b1;
                     miss_d   = '0;
                  end
               end
            end
            StLocked: begin
               word_d = word_q + 16'd1;
               // Flywheel: expected word advances regardless of received data.
               exp_d  = lfsr_next(exp_q);
               if (data_in != exp_q) begin
                  err_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                  miss_d = miss_q + 4'd1;
`ifdef ERR_CAPTURE_EN
                  if (!cap_q) begin
                     cap_d     = 1'b1;
                     cap_exp_d = exp_q;
                     cap_rcv_d = data_in;
                     cap_idx_d = word_q;
                  end
`endif
               end else begin
                  miss_d = '0;
               end
               if (word_d == PatLen) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else if (miss_d == LossCnt) begin
                  state_d  = StHunt;
                  locked_d = 1'b0;
                  match_d  = '0;
                  miss_d   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         exp_q    <= 9'h1FF;
         match_q  <= '0;
         miss_q   <= '0;
         err_q    <= '0;
         word_q   <= '0;
         locked_q <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
`ifdef ERR_CAPTURE_EN
         cap_q     <= 1'b0;
         cap_exp_q <= '0;
         cap_rcv_q <= '0;
         cap_idx_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         err_q    <= err_d;
         word_q   <= word_d;
         locked_q <= locked_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
`ifdef ERR_CAPTURE_EN
         cap_q     <= cap_d;
         cap_exp_q <= cap_exp_d;
         cap_rcv_q <= cap_rcv_d;
         cap_idx_q <= cap_idx_d;
`endif
      end
   end

   assign locked         = locked_q;
   assign done           = done_q;
   assign fault_detected = fault_q;
   assign err_count      = err_q;
   assign word_count     = word_q;
`ifdef ERR_CAPTURE_EN
   assign first_err_exp = cap_exp_q;
   assign first_err_rcv = cap_rcv_q;
   assign first_err_idx = cap_idx_q;
`endif

endmodule

// File: tb/tb_lfsr_pattern_checker.sv
// Directed self-checking bench for lfsr_pattern_checker; expected values computed by hand
// and from a local LFSR step function.
module tb_lfsr_pattern_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        data_valid = 1'b0;
   logic [8:0]  data_in = '0;
   logic        locked, done, fault_detected;
   logic [15:0] err_count, word_count;
`ifdef ERR_CAPTURE_EN
   logic [8:0]  first_err_exp, first_err_rcv;
   logic [15:0] first_err_idx;
`endif

   int errors = 0;
   int checks = 0;
   logic [8:0] cur;

   lfsr_pattern_checker dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .data_valid     (data_valid),
      .data_in        (data_in),
      .locked         (locked),
      .done           (done),
      .fault_detected (fault_detected),
      .err_count      (err_count),
`ifdef ERR_CAPTURE_EN
      .first_err_exp  (first_err_exp),
      .first_err_rcv  (first_err_rcv),
      .first_err_idx  (first_err_idx),
`endif
      .word_count     (word_count)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] step(input logic [8:0] s);
      return {s[7:0], s[8] ^ s[4]};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic v, input logic [8:0] d);
      data_valid = v;
      data_in    = d;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   task automatic send_next();
      send(1'b1, cur);
      cur = step(cur);
   endtask

   task automatic pulse_start(input logic v, input logic [8:0] d);
      start      = 1'b1;
      data_valid = v;
      data_in    = d;
      @(posedge clk);
      #1;
      start      = 1'b0;
      data_valid = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_locked", {15'd0, locked}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_fault", {15'd0, fault_detected}, 16'd0);
      chk("rst_err", err_count, 16'd0);
      chk("rst_words", word_count, 16'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(1'b1, 9'h001);
      chk("idle_ignores", {15'd0, locked}, 16'd0);

      // Clean stream from seed 1
      pulse_start(1'b0, 9'h000);
      cur = 9'h001;
      send_next();
      send_next();
      chk("clean_not_locked_2", {15'd0, locked}, 16'd0);
      send_next();
      chk("clean_locked_3", {15'd0, locked}, 16'd1);
      for (int i = 0; i < 510; i++) send_next();
      chk("clean_words_510", word_count, 16'd510);
      chk("clean_not_done", {15'd0, done}, 16'd0);
      send_next();
      chk("clean_done", {15'd0, done}, 16'd1);
      chk("clean_words_511", word_count, 16'd511);
      for (int i = 0; i < 86; i++) send_next();
      chk("done_ignores", word_count, 16'd511);
      chk("done_locked", {15'd0, locked}, 16'd1);
      chk("clean_err", err_count, 16'd0);
      chk("clean_fault", {15'd0, fault_detected}, 16'd0);

      // Single error on 10th locked word
      pulse_start(1'b0, 9'h000);
      chk("restart_done_clr", {15'd0, done}, 16'd0);
      cur = 9'h0A5;
      for (int i = 0; i < 3; i++) send_next();
      for (int i = 0; i < 9; i++) send_next();
      send(1'b1, cur ^ 9'h001);
      cur = step(cur);
      chk("err_count_1", err_count, 16'd1);
      chk("err_fault_lag", {15'd0, fault_detected}, 16'd0);
      chk("err_words_10", word_count, 16'd10);
      send(1'b0, 9'h000);
      chk("err_fault_set", {15'd0, fault_detected}, 16'd1);
      chk("err_still_locked", {15'd0, locked}, 16'd1);
`ifdef ERR_CAPTURE_EN
      chk("cap_idx", first_err_idx, 16'd9);
      chk("cap_diff", {7'd0, first_err_exp ^ first_err_rcv}, 16'h0001);
`endif
      send_next();
      chk("err_word11_ok", err_count, 16'd1);

      // Loss of sync
      for (int i = 0; i < 3; i++) send(1'b1, 9'h000);
      chk("loss_3_locked", {15'd0, locked}, 16'd1);
      send(1'b1, 9'h000);
      chk("loss_4_unlocked", {15'd0, locked}, 16'd0);
      chk("loss_err_5", err_count, 16'd5);
      chk("loss_words_15", word_count, 16'd15);
      cur = 9'h133;
      send_next();
      send_next();
      chk("relock_not_2", {15'd0, locked}, 16'd0);
      send_next();
      chk("relock_3", {15'd0, locked}, 16'd1);
      chk("relock_words_kept", word_count, 16'd15);
      chk("fault_sticky", {15'd0, fault_detected}, 16'd1);

      // Start with data_valid mid-LOCKED clears everything
      pulse_start(1'b1, cur);
      chk("start_locked", {15'd0, locked}, 16'd0);
      chk("start_err", err_count, 16'd0);
      chk("start_words", word_count, 16'd0);
      send(1'b0, 9'h000);
      chk("start_fault", {15'd0, fault_detected}, 16'd0);

      // Gapped valid
      cur = 9'h155;
      for (int i = 0; i < 3; i++) begin
         send_next();
         send(1'b0, 9'h000);
      end
      chk("gap_locked", {15'd0, locked}, 16'd1);
      for (int i = 0; i < 6; i++) begin
         send_next();
         send(1'b0, 9'h1AA);
      end
      chk("gap_words", word_count, 16'd6);
      chk("gap_err", err_count, 16'd0);

      // Zero words in HUNT
      pulse_start(1'b0, 9'h000);
      for (int i = 0; i < 10; i++) send(1'b1, 9'h000);
      chk("zero_no_lock", {15'd0, locked}, 16'd0);
      chk("zero_no_words", word_count, 16'd0);
      cur = 9'h0F0;
      send_next();
      send_next();
      send(1'b1, 9'h000);
      send_next();
      send_next();
      chk("zero_resets_match", {15'd0, locked}, 16'd0);
      send_next();
      chk("zero_then_lock", {15'd0, locked}, 16'd1);
      send_next();
      send_next();
      chk("zero_words_2", word_count, 16'd2);

      // Async reset between edges while locked
      #3 rst_n = 1'b0;
      #1;
      chk("async_locked", {15'd0, locked}, 16'd0);
      chk("async_words", word_count, 16'd0);
      #2 rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
